// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and constants for the PWM fader block.
//   fade_state_t : gain-ramp FSM state
//   PWM_W        : default sample/counter width
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } fade_state_t;

    localparam int PWM_W = 8;

endpackage

// File: rtl/pwm_fader_if.sv
// pwm_fader_if: waveshaper-side bundle for the PWM fader.
//   en            synth enable (master -> slave)
//   sample        WIDTH-bit sample (master -> slave)
//   pwm_out       1-bit PWM stream (slave -> master)
//   active        fader not idle (slave -> master)
//   period_strobe boundary-cycle pulse, only with PWM_PERIOD_STROBE_EN
// Modports: master = upstream/driver side, slave = pwm_fader.
interface pwm_fader_if
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_W
);
    logic             en;
    logic [WIDTH-1:0] sample;
    logic             pwm_out;
    logic             active;
`ifdef PWM_PERIOD_STROBE_EN
    logic             period_strobe;

    modport master (output en, sample, input  pwm_out, active, period_strobe);
    modport slave  (input  en, sample, output pwm_out, active, period_strobe);
`else
    modport master (output en, sample, input  pwm_out, active);
    modport slave  (input  en, sample, output pwm_out, active);
`endif

endinterface

// File: rtl/pwm_fader_ramp.sv
// fade_ramp: gain-ramp FSM with saturating gain register.
//   clk, n_rst   clock, synchronous active-low reset
//   boundary_i   high in the last cycle of each PWM period; all updates happen
//                on the edge leaving that cycle
//   en_i         synth enable, only its value in the boundary cycle matters
//   gain_next_o  gain that will be loaded at the next boundary edge
//                (0..2**WIDTH, 2**WIDTH = unity)
//   active_o     registered "state != IDLE"
module fade_ramp
    import pwm_pkg::*;
#(
    parameter int WIDTH     = PWM_W,
    parameter int RAMP_STEP = 1
)(
    input  logic           clk,
    input  logic           n_rst,
    input  logic           boundary_i,
    input  logic           en_i,
    output logic [WIDTH:0] gain_next_o,
    output logic           active_o
);

    // Two spare bits above the gain so gain+RAMP_STEP (up to 2*2**WIDTH)
    // cannot wrap before the saturation compare.
    localparam logic [WIDTH+1:0] FULL = {2'b01, {WIDTH{1'b0}}};
    localparam logic [WIDTH+1:0] STEP = (WIDTH+2)'(RAMP_STEP);

    fade_state_t      state_q, state_d;
    logic [WIDTH:0]   gain_q, gain_d;
    logic             active_q;
    logic [WIDTH+1:0] g, sum, up, dn;

    always_comb begin
        g   = {1'b0, gain_q};
        sum = g + STEP;
        up  = (sum > FULL) ? FULL : sum;
        dn  = (g > STEP) ? (g - STEP) : '0;

        state_d = state_q;
        gain_d  = gain_q;
        case (state_q)
            IDLE: begin
                if (en_i) begin
                    gain_d  = up[WIDTH:0];
                    state_d = RAMP_UP;
                end else begin
                    gain_d  = '0;
                end
            end
            RAMP_UP: begin
                if (!en_i) begin
                    gain_d  = dn[WIDTH:0];
                    state_d = RAMP_DOWN;
                end else begin
                    gain_d  = up[WIDTH:0];
                    if (up == FULL) state_d = RUN;
                end
            end
            RUN: begin
                if (!en_i) begin
                    gain_d  = dn[WIDTH:0];
                    state_d = RAMP_DOWN;
                end else begin
                    gain_d  = FULL[WIDTH:0];
                end
            end
            RAMP_DOWN: begin
                if (en_i) begin
                    gain_d  = up[WIDTH:0];
                    state_d = RAMP_UP;
                end else begin
                    gain_d  = dn[WIDTH:0];
                    if (dn == '0) state_d = IDLE;
                end
            end
            default: begin
                gain_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            gain_q   <= '0;
            active_q <= 1'b0;
        end else if (boundary_i) begin
            state_q  <= state_d;
            gain_q   <= gain_d;
            active_q <= (state_d != IDLE);
        end
    end

    assign gain_next_o = gain_d;
    assign active_o    = active_q;

endmodule

// File: rtl/pwm_fader.sv
// pwm_fader: 8-bit sample -> 1-bit PWM with a period-synchronous gain ramp
// (fade-in on enable, fade-out on disable). The sample is latched once per
// PWM period, on the edge leaving the boundary cycle (cnt == 2**WIDTH-1).
//   clk    system clock
//   n_rst  synchronous active-low reset
//   bus    pwm_fader_if.slave: en, sample in; pwm_out, active out
//          (+ period_strobe when PWM_PERIOD_STROBE_EN is defined)
// Optional feature macro: PWM_PERIOD_STROBE_EN.
module pwm_fader
    import pwm_pkg::*;
#(
    parameter int WIDTH     = PWM_W,
    parameter int RAMP_STEP = 1
)(
    input  logic        clk,
    input  logic        n_rst,
    pwm_fader_if.slave  bus
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH:0]   gain_next;
    logic [2*WIDTH:0] prod;
    logic             boundary;

    assign boundary = &cnt_q;
    assign cnt_d    = cnt_q + 1'b1;

    fade_ramp #(
        .WIDTH     (WIDTH),
        .RAMP_STEP (RAMP_STEP)
    ) u_ramp (
        .clk         (clk),
        .n_rst       (n_rst),
        .boundary_i  (boundary),
        .en_i        (bus.en),
        .gain_next_o (gain_next),
        .active_o    (bus.active)
    );

    // Scale by the gain that takes effect this boundary; >>WIDTH keeps the
    // result within WIDTH bits since gain <= 2**WIDTH.
    assign prod   = {{(WIDTH+1){1'b0}}, bus.sample} * {{WIDTH{1'b0}}, gain_next};
    assign duty_d = prod[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt_q  <= '0;
            duty_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (boundary) duty_q <= duty_d;
        end
    end

    assign bus.pwm_out = (cnt_q < duty_q);

`ifdef PWM_PERIOD_STROBE_EN
    assign bus.period_strobe = boundary;
`endif

endmodule

// File: tb/tb_pwm_fader.sv
// tb_pwm_fader: two faders (RAMP_STEP 64 and 48) share clock, reset and
// stimulus. A period-level reference model (gain, active, last enable)
// predicts the high count of every PWM period and the active flag.
module tb_pwm_fader;

    localparam int W    = 8;
    localparam int FULL = 256;
    localparam int LAST = 255;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    pwm_fader_if #(.WIDTH(W)) ifa ();
    pwm_fader_if #(.WIDTH(W)) ifb ();

    pwm_fader #(.WIDTH(W), .RAMP_STEP(64)) dut_a (.clk(clk), .n_rst(n_rst), .bus(ifa));
    pwm_fader #(.WIDTH(W), .RAMP_STEP(48)) dut_b (.clk(clk), .n_rst(n_rst), .bus(ifb));

    always #5 clk = ~clk;

    int ncmp  = 0;
    int nfail = 0;
    int tcnt  = 0;
    int steps [2] = '{64, 48};
    int mg    [2] = '{0, 0};
    int mduty [2] = '{0, 0};
    int hi    [2] = '{0, 0};
    bit mact  [2] = '{0, 0};
    bit mlast [2] = '{0, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Period-level rules: enable ramps gain up (saturating at unity); without
    // enable an active fader ramps down, and it goes idle only when a period
    // that was already fading out brings the gain to zero.
    task automatic model_boundary(input bit e, input int s);
        for (int k = 0; k < 2; k++) begin
            bit was_down;
            was_down = mact[k] && !mlast[k];
            if (e) begin
                mg[k]   = (mg[k] + steps[k] > FULL) ? FULL : mg[k] + steps[k];
                mact[k] = 1'b1;
            end else if (mact[k]) begin
                mg[k] = (mg[k] > steps[k]) ? mg[k] - steps[k] : 0;
                if (was_down && mg[k] == 0) mact[k] = 1'b0;
            end else begin
                mg[k] = 0;
            end
            mlast[k] = e;
            mduty[k] = (s * mg[k]) / FULL;
        end
    endtask

    task automatic drive(input bit e, input logic [7:0] s);
        ifa.en = e; ifb.en = e;
        ifa.sample = s; ifb.sample = s;
    endtask

    // One clock: observe at #1 after the previous edge, then advance.
    task automatic cyc(input bit e, input logic [7:0] s);
        drive(e, s);
        if (tcnt == 0) begin
            chk("active_a", {31'd0, ifa.active}, {31'd0, mact[0]});
            chk("active_b", {31'd0, ifb.active}, {31'd0, mact[1]});
        end
        if (ifa.pwm_out === 1'b1) hi[0]++;
        if (ifb.pwm_out === 1'b1) hi[1]++;
`ifdef PWM_PERIOD_STROBE_EN
        chk("strobe_a", {31'd0, ifa.period_strobe}, {31'd0, (tcnt == LAST)});
`endif
        if (tcnt == LAST) begin
            chk("highs_a", hi[0], mduty[0]);
            chk("highs_b", hi[1], mduty[1]);
            hi[0] = 0; hi[1] = 0;
        end
        @(posedge clk);
        if (tcnt == LAST) model_boundary(e, int'(s));
        tcnt = (tcnt + 1) % FULL;
        #1;
    endtask

    // One full period; inputs switch from (e0,s0) to (e1,s1) at cnt == sw,
    // so the boundary cycle always sees (e1,s1).
    task automatic period(input bit e0, input logic [7:0] s0,
                          input bit e1, input logic [7:0] s1, input int sw);
        for (int c = 0; c < FULL; c++) begin
            if (tcnt < sw) cyc(e0, s0);
            else           cyc(e1, s1);
        end
    endtask

    task automatic run(input int n, input bit e, input logic [7:0] s);
        for (int i = 0; i < n; i++) period(e, s, e, s, 0);
    endtask

    task automatic do_reset(input int n, input bit e, input logic [7:0] s);
        n_rst = 1'b0;
        drive(e, s);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("rst_pwm_a",    {31'd0, ifa.pwm_out}, 32'd0);
            chk("rst_pwm_b",    {31'd0, ifb.pwm_out}, 32'd0);
            chk("rst_active_a", {31'd0, ifa.active},  32'd0);
            chk("rst_active_b", {31'd0, ifb.active},  32'd0);
`ifdef PWM_PERIOD_STROBE_EN
            chk("rst_strobe_a", {31'd0, ifa.period_strobe}, 32'd0);
`endif
        end
        n_rst = 1'b1;
        tcnt  = 0;
        for (int k = 0; k < 2; k++) begin
            mg[k] = 0; mduty[k] = 0; hi[k] = 0; mact[k] = 1'b0; mlast[k] = 1'b0;
        end
    endtask

    initial begin
        // Reset held 3 clocks with enable up; first boundary then comes
        // exactly 256 clocks after release.
        do_reset(3, 1'b1, 8'd200);
        run(1, 1'b1, 8'd200);

        // Fade-in to unity, steady state.
        run(6, 1'b1, 8'd128);

        // Fade-out from full scale to idle.
        run(1, 1'b1, 8'd255);
        run(7, 1'b0, 8'd255);

        // Interrupted fade-in / fade-out, then fade back in from zero.
        run(2, 1'b1, 8'd200);
        run(2, 1'b0, 8'd200);
        run(6, 1'b1, 8'd200);

        // Mid-period sample change is only seen in the next period.
        run(1, 1'b1, 8'd100);
        period(1'b1, 8'd100, 1'b1, 8'd10, 50);
        run(1, 1'b1, 8'd10);

        // Enable glitches between boundaries are ignored.
        period(1'b0, 8'd77, 1'b1, 8'd77, 200);
        period(1'b1, 8'd77, 1'b0, 8'd77, 255);
        run(2, 1'b1, 8'd77);

        // Randomized blocks: hold the boundary enable for a random run of
        // periods while scrambling inputs inside each period.
        for (int b = 0; b < 12; b++) begin
            bit e;
            int len;
            e   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 6));
            for (int p = 0; p < len; p++)
                period(1'($urandom_range(0, 1)), 8'($urandom), e, 8'($urandom),
                       int'($urandom_range(0, 255)));
        end

        // Reset in the middle of a fade-in aborts it immediately.
        run(1, 1'b0, 8'd0);
        run(2, 1'b1, 8'd180);
        for (int i = 0; i < 100; i++) cyc(1'b1, 8'd180);
        do_reset(1, 1'b0, 8'd180);
        run(2, 1'b0, 8'd180);
        run(3, 1'b1, 8'd180);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
